// File: rtl/mac_pe_pkg.sv
// Shared types and helpers for the second-generation systolic MAC PE.
package mac_pe_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  localparam int unsigned DEF_IFMAP_W = 16;
  localparam int unsigned DEF_W_W     = 8;
  localparam int unsigned PROD_W      = DEF_IFMAP_W + DEF_W_W;
  localparam int unsigned MAX_W       = 64;

  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic             ovf;
  } sat_res_t;

  // value holds a (width+1)-bit sum sign-extended to MAX_W; result is valid in [width-1:0].
  function automatic sat_res_t sat_trunc(input logic signed [MAX_W-1:0] value,
                                         input int unsigned width, input bit saturate);
    sat_res_t res;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    max_v     = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v     = -max_v - 64'sd1;
    res.ovf   = value[width] != value[width-1];
    res.value = value;
    if (res.ovf && saturate) begin
      res.value = value[width] ? min_v : max_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed multiply-add with optional saturation and overflow detect.
module mac_sat_add
  import mac_pe_pkg::*;
#(
  parameter int unsigned IFMAP_BITWIDTH = 16,
  parameter int unsigned W_BITWIDTH     = 8,
  parameter int unsigned OFMAP_BITWIDTH = 32,
  parameter bit          SATURATE       = 1'b1
) (
  input  logic signed [IFMAP_BITWIDTH-1:0] a,
  input  logic signed [W_BITWIDTH-1:0]     b,
  input  logic signed [OFMAP_BITWIDTH-1:0] addend,
  output logic signed [OFMAP_BITWIDTH-1:0] sum,
  output logic                             ovf
);

  localparam int unsigned ProdW = IFMAP_BITWIDTH + W_BITWIDTH;

  logic signed [ProdW-1:0]        a_ext;
  logic signed [ProdW-1:0]        b_ext;
  logic signed [ProdW-1:0]        prod;
  logic signed [OFMAP_BITWIDTH:0] sum_ext;
  logic signed [MAX_W-1:0]        sum_wide;
  sat_res_t                       res;
  logic                           unused_hi;

  assign a_ext = $signed({{W_BITWIDTH{a[IFMAP_BITWIDTH-1]}}, a});
  assign b_ext = $signed({{IFMAP_BITWIDTH{b[W_BITWIDTH-1]}}, b});
  // Low ProdW bits of the extended product equal the exact signed product.
  assign prod  = a_ext * b_ext;

  assign sum_ext  = $signed({{(OFMAP_BITWIDTH + 1 - ProdW){prod[ProdW-1]}}, prod})
                  + $signed({addend[OFMAP_BITWIDTH-1], addend});
  assign sum_wide = $signed({{(MAX_W - OFMAP_BITWIDTH - 1){sum_ext[OFMAP_BITWIDTH]}}, sum_ext});

  assign res       = sat_trunc(sum_wide, OFMAP_BITWIDTH, SATURATE);
  assign sum       = res.value[OFMAP_BITWIDTH-1:0];
  assign ovf       = res.ovf;
  assign unused_hi = ^res.value[MAX_W-1:OFMAP_BITWIDTH];

endmodule

// File: rtl/mac_pe_v2.sv
// Systolic PE: registered ifmap/weight pass-through, WS multiply-add with double-buffered
// weights, or OS accumulate with a psum drain chain.
module mac_pe_v2
  import mac_pe_pkg::*;
#(
  parameter int unsigned IFMAP_BITWIDTH = 16,
  parameter int unsigned W_BITWIDTH     = 8,
  parameter int unsigned OFMAP_BITWIDTH = 32,
  parameter int unsigned SATURATE       = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             mode,
  input  logic                             ifmap_valid_in,
  input  logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  output logic                             ifmap_valid_out,
  output logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  input  logic                             w_valid_in,
  input  logic signed [W_BITWIDTH-1:0]     w_data_in,
  output logic                             w_valid_out,
  output logic signed [W_BITWIDTH-1:0]     w_data_out,
  input  logic                             w_swap,
  input  logic                             psum_valid_in,
  input  logic signed [OFMAP_BITWIDTH-1:0] psum_data_in,
  output logic                             psum_valid_out,
  output logic signed [OFMAP_BITWIDTH-1:0] psum_data_out,
  input  logic                             drain_in,
  output logic                             drain_out,
  input  logic                             acc_clear,
  output logic                             ovf
);

  pe_mode_e                        mode_e;
  logic                            is_os;
  logic                            fire;
  logic signed [W_BITWIDTH-1:0]    w_shadow;
  logic signed [W_BITWIDTH-1:0]    w_active;
  logic signed [W_BITWIDTH-1:0]    mul_w;
  logic signed [OFMAP_BITWIDTH-1:0] acc;
  logic signed [OFMAP_BITWIDTH-1:0] addend;
  logic signed [OFMAP_BITWIDTH-1:0] mac_sum;
  logic                            mac_ovf;

  assign mode_e = pe_mode_e'(mode);
  assign is_os  = (mode_e == PE_OS);
  assign fire   = is_os ? (ifmap_valid_in & w_valid_in) : ifmap_valid_in;
  assign mul_w  = is_os ? w_data_in : w_active;

  // A zero addend on clear/drain makes the shared adder yield the bare product.
  always_comb begin
    addend = '0;
    if (is_os) begin
      if (!(acc_clear || drain_in)) addend = acc;
    end else if (psum_valid_in) begin
      addend = psum_data_in;
    end
  end

  mac_sat_add #(
    .IFMAP_BITWIDTH(IFMAP_BITWIDTH),
    .W_BITWIDTH    (W_BITWIDTH),
    .OFMAP_BITWIDTH(OFMAP_BITWIDTH),
    .SATURATE      (SATURATE != 0)
  ) u_mac (
    .a     (ifmap_data_in),
    .b     (mul_w),
    .addend(addend),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifmap_valid_out <= 1'b0;
      ifmap_data_out  <= '0;
      w_valid_out     <= 1'b0;
      w_data_out      <= '0;
      psum_valid_out  <= 1'b0;
      psum_data_out   <= '0;
      drain_out       <= 1'b0;
      ovf             <= 1'b0;
      w_shadow        <= '0;
      w_active        <= '0;
      acc             <= '0;
    end else begin
      ifmap_valid_out <= ifmap_valid_in;
      w_valid_out     <= w_valid_in;
      if (ifmap_valid_in) ifmap_data_out <= ifmap_data_in;
      if (w_valid_in)     w_data_out     <= w_data_in;

      if (!is_os) begin
        drain_out <= 1'b0;
        if (w_valid_in) w_shadow <= w_data_in;
        if (w_swap)     w_active <= w_valid_in ? w_data_in : w_shadow;
        psum_valid_out <= ifmap_valid_in;
        if (ifmap_valid_in) begin
          psum_data_out <= mac_sum;
          if (mac_ovf) ovf <= 1'b1;
        end
      end else begin
        drain_out <= drain_in;
        if (acc_clear || drain_in) begin
          acc <= fire ? mac_sum : '0;
        end else if (fire) begin
          acc <= mac_sum;
        end
        if (acc_clear) begin
          ovf <= 1'b0;
        end else if (fire && mac_ovf) begin
          ovf <= 1'b1;
        end
        if (drain_in) begin
          psum_data_out  <= acc;
          psum_valid_out <= 1'b1;
        end else if (psum_valid_in) begin
          psum_data_out  <= psum_data_in;
          psum_valid_out <= 1'b1;
        end else begin
          psum_valid_out <= 1'b0;
        end
      end
    end
  end

  a_mode_stable : assert property (@(posedge clk) disable iff (!rstn)
    $changed(mode) |-> !(ifmap_valid_in || w_valid_in || psum_valid_in));

  a_drain_collision : assert property (@(posedge clk) disable iff (!rstn)
    is_os |-> !(drain_in && psum_valid_in));

endmodule

// File: tb/tb_mac_pe_v2.sv
// Scoreboard bench for mac_pe_v2: one saturating and one wrapping instance share stimulus.
module tb_mac_pe_v2;

  logic               clk = 1'b0;
  logic               rstn;
  logic               mode;
  logic               ifmap_valid_in;
  logic signed [15:0] ifmap_data_in;
  logic               w_valid_in;
  logic signed [7:0]  w_data_in;
  logic               w_swap;
  logic               psum_valid_in;
  logic signed [31:0] psum_data_in;
  logic               drain_in;
  logic               acc_clear;

  logic               ifmap_valid_out, w_valid_out, psum_valid_out, drain_out, ovf;
  logic signed [15:0] ifmap_data_out;
  logic signed [7:0]  w_data_out;
  logic signed [31:0] psum_data_out;

  logic               ifmap_valid_out_w, w_valid_out_w, psum_valid_out_w, drain_out_w, ovf_w;
  logic signed [15:0] ifmap_data_out_w;
  logic signed [7:0]  w_data_out_w;
  logic signed [31:0] psum_data_out_w;

  int n_vec = 0;
  int n_err = 0;
  logic signed [31:0] exp_q[$];
  logic signed [31:0] exp_w_q[$];
  longint acc_model;
  longint big;

  always #5 clk = ~clk;

  mac_pe_v2 #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SATURATE(1)) dut (
    .clk(clk), .rstn(rstn), .mode(mode),
    .ifmap_valid_in(ifmap_valid_in), .ifmap_data_in(ifmap_data_in),
    .ifmap_valid_out(ifmap_valid_out), .ifmap_data_out(ifmap_data_out),
    .w_valid_in(w_valid_in), .w_data_in(w_data_in),
    .w_valid_out(w_valid_out), .w_data_out(w_data_out), .w_swap(w_swap),
    .psum_valid_in(psum_valid_in), .psum_data_in(psum_data_in),
    .psum_valid_out(psum_valid_out), .psum_data_out(psum_data_out),
    .drain_in(drain_in), .drain_out(drain_out), .acc_clear(acc_clear), .ovf(ovf)
  );

  mac_pe_v2 #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SATURATE(0)) dut_w (
    .clk(clk), .rstn(rstn), .mode(mode),
    .ifmap_valid_in(ifmap_valid_in), .ifmap_data_in(ifmap_data_in),
    .ifmap_valid_out(ifmap_valid_out_w), .ifmap_data_out(ifmap_data_out_w),
    .w_valid_in(w_valid_in), .w_data_in(w_data_in),
    .w_valid_out(w_valid_out_w), .w_data_out(w_data_out_w), .w_swap(w_swap),
    .psum_valid_in(psum_valid_in), .psum_data_in(psum_data_in),
    .psum_valid_out(psum_valid_out_w), .psum_data_out(psum_data_out_w),
    .drain_in(drain_in), .drain_out(drain_out_w), .acc_clear(acc_clear), .ovf(ovf_w)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] sat32(input longint v);
    if (v > 64'sd2147483647) return 32'sh7fffffff;
    if (v < -64'sd2147483648) return 32'sh80000000;
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] wrap32(input longint v);
    return 32'(v);
  endfunction

  task automatic push(input logic signed [31:0] e_sat, input logic signed [31:0] e_wrap);
    exp_q.push_back(e_sat);
    exp_w_q.push_back(e_wrap);
  endtask

  task automatic idle();
    ifmap_valid_in = 1'b0; ifmap_data_in = '0;
    w_valid_in     = 1'b0; w_data_in     = '0;
    w_swap         = 1'b0;
    psum_valid_in  = 1'b0; psum_data_in  = '0;
    drain_in       = 1'b0; acc_clear     = 1'b0;
  endtask

  // Advance one edge, then retire any produced psum against the scoreboard.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (psum_valid_out) begin
      check("sb_avail", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("psum_sat", psum_data_out, exp_q.pop_front());
    end
    if (psum_valid_out_w) begin
      check("sb_avail_w", 64'(exp_w_q.size() != 0), 1);
      if (exp_w_q.size() != 0) check("psum_wrap", psum_data_out_w, exp_w_q.pop_front());
    end
  endtask

  task automatic os_fire(input int a, input int b);
    idle();
    ifmap_valid_in = 1'b1; ifmap_data_in = 16'(a);
    w_valid_in     = 1'b1; w_data_in     = 8'(b);
    acc_model += longint'(a) * longint'(b);
    cycle();
  endtask

  initial begin
    rstn = 1'b0;
    mode = 1'b0;
    idle();
    acc_model = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psum", psum_data_out, 0);
    check("rst_psum_vld", psum_valid_out, 0);
    check("rst_ifmap", ifmap_data_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drain", drain_out, 0);
    rstn = 1'b1;

    // WS basic: shadow load, swap, multiply-add
    w_valid_in = 1'b1; w_data_in = -8'sd3;
    cycle();
    check("w_pass", w_data_out, -3);
    check("w_vld_pass", w_valid_out, 1);
    idle(); w_swap = 1'b1;
    cycle();
    idle();
    ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd100;
    psum_valid_in  = 1'b1; psum_data_in  = 32'sd1000;
    push(100 * -3 + 1000, 100 * -3 + 1000);
    cycle();
    check("ifmap_pass", ifmap_data_out, 100);
    check("ifmap_vld_pass", ifmap_valid_out, 1);
    idle();
    cycle();
    check("ws_vld_idle", psum_valid_out, 0);
    check("ws_hold", psum_data_out, 700);

    // Shadow/swap timing
    idle(); w_valid_in = 1'b1; w_data_in = 8'sd2; w_swap = 1'b1;
    cycle();
    idle(); w_valid_in = 1'b1; w_data_in = 8'sd7; ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd10;
    push(10 * 2, 10 * 2);
    cycle();
    idle(); w_swap = 1'b1;
    cycle();
    idle(); ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd10;
    push(10 * 7, 10 * 7);
    cycle();
    idle(); w_valid_in = 1'b1; w_data_in = 8'sd3; w_swap = 1'b1;
    ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd10;
    push(10 * 7, 10 * 7);
    cycle();
    idle(); ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd10;
    push(10 * 3, 10 * 3);
    cycle();

    // Saturation vs wrap, sticky ovf
    idle(); w_valid_in = 1'b1; w_data_in = 8'sd127; w_swap = 1'b1;
    cycle();
    big = 64'sd2147483000 + 64'sd32767 * 64'sd127;
    idle(); ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd32767;
    psum_valid_in = 1'b1; psum_data_in = 32'sd2147483000;
    push(sat32(big), wrap32(big));
    cycle();
    check("ovf_sat", ovf, 1);
    check("ovf_wrap", ovf_w, 1);
    idle(); ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd1;
    push(127, 127);
    cycle();
    check("ovf_sticky", ovf, 1);
    idle(); acc_clear = 1'b1;
    cycle();
    check("ovf_ws_clr_ignored", ovf, 1);

    // OS accumulate and drain
    idle(); mode = 1'b1;
    cycle();
    acc_clear = 1'b1;
    cycle();
    check("ovf_cleared", ovf, 0);
    check("ovf_cleared_w", ovf_w, 0);
    acc_model = 0;
    os_fire(1, 4);
    os_fire(2, 5);
    os_fire(3, 6);
    idle(); drain_in = 1'b1;
    push(32'(acc_model), 32'(acc_model));
    acc_model = 0;
    cycle();
    check("drain_out_hi", drain_out, 1);
    idle();
    cycle();
    check("drain_out_lo", drain_out, 0);
    check("os_vld_one_cycle", psum_valid_out, 0);
    drain_in = 1'b1;
    push(0, 0);
    cycle();

    // OS drain chain shift and drain-with-fire priority
    os_fire(3, 3);
    idle(); psum_valid_in = 1'b1; psum_data_in = 32'sd55;
    push(55, 55);
    cycle();
    idle(); drain_in = 1'b1;
    ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd2; w_valid_in = 1'b1; w_data_in = 8'sd2;
    push(32'(acc_model), 32'(acc_model));
    acc_model = 4;
    cycle();
    idle(); drain_in = 1'b1;
    push(32'(acc_model), 32'(acc_model));
    acc_model = 0;
    cycle();
    idle();
    cycle();

    // Reset mid-operation
    mode = 1'b0;
    cycle();
    ifmap_valid_in = 1'b1; ifmap_data_in = 16'sd32767;
    psum_valid_in = 1'b1; psum_data_in = 32'sd2147483000;
    push(sat32(big), wrap32(big));
    cycle();
    idle(); mode = 1'b1;
    cycle();
    os_fire(4, 8);
    idle();
    check("pre_rst_ovf", ovf, 1);
    check("pre_rst_ifmap", ifmap_data_out, 4);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_psum", psum_data_out, 0);
    check("mid_rst_ifmap", ifmap_data_out, 0);
    check("mid_rst_w", w_data_out, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_ovf_w", ovf_w, 0);
    @(negedge clk);
    rstn = 1'b1;
    acc_model = 0;
    os_fire(5, 5);
    idle(); drain_in = 1'b1;
    push(32'(acc_model), 32'(acc_model));
    cycle();
    idle();
    cycle();

    check("sb_drained", exp_q.size(), 0);
    check("sb_drained_w", exp_w_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
